// File: rtl/game_pace_timer.sv
// Pacing engine for the memory game: derives the round interval from the score
// and counts it down, issuing a one-cycle tick on each expiry.
module game_pace_timer #(
    parameter int                 CNT_W       = 28,
    parameter int                 SCORE_W     = 8,
    parameter logic [CNT_W-1:0]   BASE_PERIOD = 28'hFFFFFFF,
    parameter logic [CNT_W-1:0]   STEP        = 28'h0989680,
    parameter logic [CNT_W-1:0]   MIN_PERIOD  = 28'h17D7840,
    parameter int                 MAX_LEVEL   = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [SCORE_W-1:0] p_score,
    input  logic               expert,
    input  logic               periodic,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    output logic               tick,
    output logic               busy,
    output logic [CNT_W-1:0]   count_value,
    output logic [CNT_W-1:0]   remaining
);

    // state | meaning
    // IDLE  | no interval in progress
    // RUN   | counting down remaining
    // PAUSE | countdown frozen while pause is held
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int PW = CNT_W + SCORE_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   count_value_q, count_value_d;
    logic               tick_q, tick_d;

    logic [SCORE_W-1:0] lvl;
    logic [PW-1:0]      prod;
    logic [CNT_W-1:0]   raw;

    always_comb begin
        lvl = p_score;
        if (p_score > SCORE_W'(MAX_LEVEL)) begin
            lvl = SCORE_W'(MAX_LEVEL);
        end
        // Full-width product so a large STEP*level can never wrap below BASE_PERIOD.
        prod = {{CNT_W{1'b0}}, lvl} * {{SCORE_W{1'b0}}, STEP};
        raw  = '0;
        if (prod < {{SCORE_W{1'b0}}, BASE_PERIOD}) begin
            raw = BASE_PERIOD - prod[CNT_W-1:0];
        end
        if (expert) begin
            raw = raw >> 1;
        end
        count_value_d = (raw < MIN_PERIOD) ? MIN_PERIOD : raw;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tick_d      = 1'b0;
        if (stop) begin
            state_d     = IDLE;
            remaining_d = '0;
        end else if (start) begin
            remaining_d = count_value_q;
            state_d     = pause ? PAUSE : RUN;
        end else if (state_q != IDLE) begin
            if (pause) begin
                state_d = PAUSE;
            end else begin
                // Leaving PAUSE counts on the same edge, so a held pause costs exactly its length.
                state_d = RUN;
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - 1'b1;
                end else begin
                    tick_d = 1'b1;
                    if (periodic) begin
                        remaining_d = count_value_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            count_value_q <= BASE_PERIOD;
            tick_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            count_value_q <= count_value_d;
            tick_q        <= tick_d;
        end
    end

    assign tick        = tick_q;
    assign busy        = (state_q != IDLE);
    assign count_value = count_value_q;
    assign remaining   = remaining_q;

endmodule

// File: tb/tb_game_pace_timer.sv
// Directed self-checking bench for game_pace_timer using small bench parameters.
module tb_game_pace_timer;

    localparam int CNT_W   = 8;
    localparam int SCORE_W = 8;

    logic               clock;
    logic               reset;
    logic [SCORE_W-1:0] p_score;
    logic               expert;
    logic               periodic;
    logic               start;
    logic               stop;
    logic               pause;
    logic               tick;
    logic               busy;
    logic [CNT_W-1:0]   count_value;
    logic [CNT_W-1:0]   remaining;

    int checks = 0;
    int errors = 0;

    game_pace_timer #(
        .CNT_W       (CNT_W),
        .SCORE_W     (SCORE_W),
        .BASE_PERIOD (8'd20),
        .STEP        (8'd4),
        .MIN_PERIOD  (8'd4),
        .MAX_LEVEL   (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .p_score     (p_score),
        .expert      (expert),
        .periodic    (periodic),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .tick        (tick),
        .busy        (busy),
        .count_value (count_value),
        .remaining   (remaining)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int          map_score [5]  = '{0, 2, 4, 5, 200};
    int          map_exp   [5]  = '{20, 12, 4, 4, 4};
    int          exp_score [3]  = '{0, 3, 4};
    int          exp_exp   [3]  = '{10, 4, 4};

    initial begin
        reset = 1'b1; p_score = '0; expert = 1'b0; periodic = 1'b0;
        start = 1'b0; stop = 1'b0; pause = 1'b0;
        step();
        step();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_remaining", 32'(remaining), 32'd0);
        chk("rst_count_value", 32'(count_value), 32'd20);
        reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            p_score = SCORE_W'(map_score[i]);
            step();
            chk("map_normal", 32'(count_value), 32'(map_exp[i]));
        end
        expert = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p_score = SCORE_W'(exp_score[i]);
            step();
            chk("map_expert", 32'(count_value), 32'(exp_exp[i]));
        end
        expert = 1'b0;

        // one-shot, score 2 -> period 12, tick after edge 13
        p_score = 8'd2;
        step();
        pulse_start();
        chk("os_load", 32'(remaining), 32'd12);
        chk("os_busy0", 32'(busy), 32'd1);
        for (int e = 1; e <= 20; e++) begin
            step();
            chk("os_tick", 32'(tick), 32'(e == 13));
            chk("os_busy", 32'(busy), 32'(e < 13));
            if (e <= 12) chk("os_remaining", 32'(remaining), 32'(12 - e));
        end

        // periodic, score 0 -> ticks after edges 21, 42, 63
        p_score = 8'd0;
        periodic = 1'b1;
        step();
        pulse_start();
        for (int e = 1; e <= 63; e++) begin
            step();
            chk("per_tick", 32'(tick), 32'((e % 21) == 0));
        end
        stop = 1'b1; step(); stop = 1'b0;
        chk("per_stop_busy", 32'(busy), 32'd0);
        chk("per_stop_rem", 32'(remaining), 32'd0);

        // score change mid-interval affects only the next reload
        pulse_start();
        for (int e = 1; e <= 40; e++) begin
            step();
            if (e == 5) p_score = 8'd2;
            chk("per_chg_tick", 32'(tick), 32'(e == 21 || e == 34));
        end
        stop = 1'b1; step(); stop = 1'b0;
        periodic = 1'b0;
        p_score = 8'd0;
        step();

        // pause for 7 cycles at remaining=10 delays the tick from 21 to 28
        pulse_start();
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e == 10) begin
                chk("pz_rem_at_pause", 32'(remaining), 32'd10);
                pause = 1'b1;
            end
            if (e >= 11 && e <= 17) begin
                chk("pz_frozen", 32'(remaining), 32'd10);
                chk("pz_busy", 32'(busy), 32'd1);
            end
            if (e == 17) pause = 1'b0;
            chk("pz_tick", 32'(tick), 32'(e == 28));
        end

        // start+stop together during RUN -> idle, no tick
        pulse_start();
        for (int e = 1; e <= 5; e++) step();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("pri_busy", 32'(busy), 32'd0);
        chk("pri_rem", 32'(remaining), 32'd0);
        chk("pri_tick", 32'(tick), 32'd0);
        for (int e = 0; e < 25; e++) begin
            step();
            chk("pri_no_tick", 32'(tick), 32'd0);
        end

        // restart at remaining=3 reloads the full interval
        pulse_start();
        for (int e = 1; e <= 17; e++) step();
        chk("rs_rem3", 32'(remaining), 32'd3);
        pulse_start();
        chk("rs_reload", 32'(remaining), 32'd20);
        chk("rs_busy", 32'(busy), 32'd1);
        chk("rs_tick0", 32'(tick), 32'd0);
        for (int e = 1; e <= 20; e++) begin
            step();
            chk("rs_no_tick", 32'(tick), 32'd0);
        end
        step();
        chk("rs_tick", 32'(tick), 32'd1);
        step();

        // reset while running with remaining=1
        p_score = 8'd2;
        step();
        pulse_start();
        for (int e = 1; e <= 11; e++) step();
        chk("rr_rem1", 32'(remaining), 32'd1);
        reset = 1'b1;
        step();
        chk("rr_tick", 32'(tick), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_rem", 32'(remaining), 32'd0);
        chk("rr_count_value", 32'(count_value), 32'd20);
        reset = 1'b0;
        step();
        chk("rr_count_after", 32'(count_value), 32'd12);
        chk("rr_tick_dropped", 32'(tick), 32'd0);
        step();
        chk("rr_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
